ram_port_arbiter: RTL

//  Round-robin arbiter that shares one single-port synchronous RAM (1-cycle read latency) between two

---
 rtl/ram_port_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two
// requesters. Grants are combinational from the requests and the registered
// owner state. Bounded bursts stop either side from starving the other.
// Read data returns one cycle after the grant, to the port that issued the read.
module ram_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_BURST  = 4
) (
   input  logic                  ARB_Clk,
   input  logic                  ARB_Reset_InLow,
   input  logic                  ARB_Req0,
   input  logic                  ARB_Req1,
   input  logic                  ARB_We0,
   input  logic                  ARB_We1,
   input  logic [ADDR_WIDTH-1:0] ARB_Addr0,
   input  logic [ADDR_WIDTH-1:0] ARB_Addr1,
   input  logic [DATA_WIDTH-1:0] ARB_Wdata0,
   input  logic [DATA_WIDTH-1:0] ARB_Wdata1,
   output logic                  ARB_Gnt0,
   output logic                  ARB_Gnt1,
   output logic                  ARB_Rvalid0,
   output logic                  ARB_Rvalid1,
   output logic [DATA_WIDTH-1:0] ARB_Rdata0,
   output logic [DATA_WIDTH-1:0] ARB_Rdata1,
   output logic                  RAM_We,
   output logic                  RAM_Oe,
   output logic [ADDR_WIDTH-1:0] RAM_Address,
   output logic [DATA_WIDTH-1:0] RAM_Data_In,
   input  logic [DATA_WIDTH-1:0] RAM_Data_Out
);
   // Counter is kept at least one bit wide so MAX_BURST=1 still elaborates;
   // there it sits at 0 == CNT_MAX and forces a hand-over on every contention.
   localparam int              CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

   typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;

   state_t                       state_q, state_d;
   logic                         last_owner_q, last_owner_d;
   logic [CNT_W-1:0]             burst_cnt_q, burst_cnt_d;
   logic [1:0]                   rd_pend_q, rd_pend_d;

   logic [1:0]                   req, we, gnt, rvalid;
   logic [1:0][ADDR_WIDTH-1:0]   addr;
   logic [1:0][DATA_WIDTH-1:0]   wdata, rdata;
   logic                         own, win, any;

   assign req   = {ARB_Req1, ARB_Req0};
   assign we    = {ARB_We1, ARB_We0};
   assign addr  = {ARB_Addr1, ARB_Addr0};
   assign wdata = {ARB_Wdata1, ARB_Wdata0};

   // Owner FSM: pick the winner, advance burst count, track last owner.
   // Grants are held off while reset is asserted so the RAM sees no access.
   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      own          = (state_q == S_OWN1);
      win          = 1'b0;
      any          = 1'b0;
      if (ARB_Reset_InLow) begin
         if (state_q == S_IDLE) begin
            if (req[0] && req[1]) begin
               any = 1'b1;
               win = ~last_owner_q;
            end else if (req[0] || req[1]) begin
               any = 1'b1;
               win = req[1];
            end
            if (any) begin
               state_d     = win ? S_OWN1 : S_OWN0;
               burst_cnt_d = '0;
            end
         end else begin
            if (req[own] && (!req[~own] || burst_cnt_q != CNT_MAX)) begin
               // owner keeps the port; count saturates when uncontended
               any = 1'b1;
               win = own;
               if (burst_cnt_q != CNT_MAX) burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end else if (req[~own]) begin
               any         = 1'b1;
               win         = ~own;
               state_d     = own ? S_OWN0 : S_OWN1;
               burst_cnt_d = '0;
            end else begin
               state_d     = S_IDLE;
               burst_cnt_d = '0;
            end
         end
         if (any) last_owner_d = win;
      end
   end

   // Grant decode and RAM port mux; a read is flagged for return next cycle.
   always_comb begin
      gnt         = '0;
      RAM_We      = 1'b0;
      RAM_Oe      = 1'b0;
      RAM_Address = '0;
      RAM_Data_In = '0;
      if (any) begin
         gnt[win]    = 1'b1;
         RAM_We      = we[win];
         RAM_Oe      = ~we[win];
         RAM_Address = addr[win];
         RAM_Data_In = wdata[win];
      end
      rd_pend_d = gnt & ~we;
   end

   // State registers; reset leaves port 1 as last owner so port 0 wins first.
   always_ff @(posedge ARB_Clk or negedge ARB_Reset_InLow) begin
      if (!ARB_Reset_InLow) begin
         state_q      <= S_IDLE;
         last_owner_q <= 1'b1;
         burst_cnt_q  <= '0;
         rd_pend_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         rd_pend_q    <= rd_pend_d;
      end
   end

   // Per-port read return: data is forced to zero when not valid.
   for (genvar p = 0; p < 2; p++) begin : g_ret
      assign rvalid[p] = rd_pend_q[p];
      assign rdata[p]  = rd_pend_q[p] ? RAM_Data_Out : '0;
   end

   assign ARB_Gnt0    = gnt[0];
   assign ARB_Gnt1    = gnt[1];
   assign ARB_Rvalid0 = rvalid[0];
   assign ARB_Rvalid1 = rvalid[1];
   assign ARB_Rdata0  = rdata[0];
   assign ARB_Rdata1  = rdata[1];
endmodule
